multi_start_counter: RTL and testbench

Parametrised, multi-channel successor to the single start-gated counter. Each channel waits at zero for `start`, then advances by `STEP` on every cycle its `start` is high and holds while it is low. On reaching a shared runtime limit, a channel either wraps to zero or saturates, according to a per-channel mode, and emits a one-cycle `done` pulse. The block sits beside the control FSMs as a bank of independent event/delay counters with a common clock and reset.

---
 rtl/multi_start_counter_if.sv | 26 ++
 rtl/multi_start_counter.sv | 118 +++++++++++
 tb/tb_multi_start_counter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/multi_start_counter_if.sv
// Bundles the per-channel control inputs and status outputs of the
// multi_start_counter. The master side drives the request/config signals, and
// the slave side (the counter bank) drives the count and status outputs.
interface multi_start_counter_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0]       start;
    logic [CHANNELS-1:0]       clear;
    logic [CHANNELS-1:0]       mode;
    logic [WIDTH-1:0]          limit;
    logic [CHANNELS*WIDTH-1:0] count;
    logic [CHANNELS-1:0]       busy;
    logic [CHANNELS-1:0]       done;
    logic                      all_idle;

    modport master (
        output start, clear, mode, limit,
        input  count, busy, done, all_idle
    );

    modport slave (
        input  start, clear, mode, limit,
        output count, busy, done, all_idle
    );
endinterface

// File: rtl/multi_start_counter.sv
// Bank of independent start-gated counters that share one runtime limit.
// Each channel counts by STEP while its start is high and pauses while start is
// low. On reaching the limit, the channel either wraps to zero or saturates at
// the limit, and it pulses done for one cycle.
module multi_start_counter #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int STEP     = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    multi_start_counter_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_SAT  = 2'd2
    } state_t;

    // The sum is computed one bit wider so that count + STEP cannot wrap
    // silently before it is compared with the limit.
    localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

    logic [CHANNELS*WIDTH-1:0] count_vec;
    logic [CHANNELS-1:0]       busy_vec;
    logic [CHANNELS-1:0]       done_vec;
    logic [CHANNELS-1:0]       idle_vec;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            state_t           state_q, state_d;
            logic [WIDTH-1:0] count_q, count_d;
            logic             mode_q, mode_d;
            logic             done_q, done_d;
            logic [WIDTH:0]   sum;
            logic             do_step;
            logic             step_mode;

            assign sum = {1'b0, count_q} + STEP_X;

            // Next-state logic. Clear has priority over counting.
            // In IDLE, the mode input is latched in the same cycle as the first
            // step, so that step already uses the new mode.
            always_comb begin
                state_d   = state_q;
                count_d   = count_q;
                mode_d    = mode_q;
                done_d    = 1'b0;
                do_step   = 1'b0;
                step_mode = mode_q;
                if (bus.clear[gi]) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end else begin
                    unique case (state_q)
                        ST_IDLE: begin
                            if (bus.start[gi]) begin
                                mode_d    = bus.mode[gi];
                                step_mode = bus.mode[gi];
                                do_step   = 1'b1;
                            end
                        end
                        ST_RUN: begin
                            do_step = bus.start[gi];
                        end
                        ST_SAT: begin
                            // Holds the limit captured on entry until cleared.
                        end
                        default: begin
                            state_d = ST_IDLE;
                            count_d = '0;
                        end
                    endcase
                    if (do_step) begin
                        if (sum < {1'b0, bus.limit}) begin
                            count_d = sum[WIDTH-1:0];
                            state_d = ST_RUN;
                        end else if (step_mode) begin
                            count_d = bus.limit;
                            state_d = ST_SAT;
                            done_d  = 1'b1;
                        end else begin
                            count_d = '0;
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end

            // State register with synchronous reset. Reset discards any terminal
            // step that is in flight.
            always_ff @(posedge clk) begin
                if (reset) begin
                    state_q <= ST_IDLE;
                    count_q <= '0;
                    mode_q  <= 1'b0;
                    done_q  <= 1'b0;
                end else begin
                    state_q <= state_d;
                    count_q <= count_d;
                    mode_q  <= mode_d;
                    done_q  <= done_d;
                end
            end

            assign count_vec[gi*WIDTH +: WIDTH] = count_q;
            assign busy_vec[gi]                 = (state_q == ST_RUN);
            assign done_vec[gi]                 = done_q;
            assign idle_vec[gi]                 = (state_q == ST_IDLE);
        end
    endgenerate

    assign bus.count    = count_vec;
    assign bus.busy     = busy_vec;
    assign bus.done     = done_vec;
    assign bus.all_idle = &idle_vec;
endmodule

// File: tb/tb_multi_start_counter.sv
// Testbench for multi_start_counter. Two banks are instantiated: a 4-channel
// bank with STEP=1 and a 2-channel bank with STEP=3. Bank B's channels share
// inputs with bank A's channels 0 and 1.
module tb_multi_start_counter;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multi_start_counter_if #(.WIDTH(W), .CHANNELS(4)) ifa ();
    multi_start_counter_if #(.WIDTH(W), .CHANNELS(2)) ifb ();

    multi_start_counter #(.WIDTH(W), .CHANNELS(4), .STEP(1)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa.slave));
    multi_start_counter #(.WIDTH(W), .CHANNELS(2), .STEP(3)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb.slave));

    // Stimulus values applied to both banks.
    logic [3:0]   st_v, cl_v, md_v;
    logic [W-1:0] lim_v;
    logic         rs_v;

    // Reference model. Entries 0..3 are bank A and entries 4..5 are bank B.
    int m_cnt [6];
    bit m_run [6];
    bit m_sat [6];
    bit m_mq  [6];
    bit m_done[6];

    int n_total = 0;
    int n_pass  = 0;

    // Advance the model by one rising edge, using the inputs that were sampled.
    function automatic void model_edge();
        for (int j = 0; j < 6; j++) begin
            int k;
            int stp;
            int sum;
            bit md;
            k   = (j < 4) ? j : j - 4;
            stp = (j < 4) ? 1 : 3;
            if (rs_v) begin
                m_cnt[j] = 0; m_run[j] = 0; m_sat[j] = 0; m_mq[j] = 0; m_done[j] = 0;
            end else if (cl_v[k]) begin
                m_cnt[j] = 0; m_run[j] = 0; m_sat[j] = 0; m_done[j] = 0;
            end else if (m_sat[j]) begin
                m_done[j] = 0;
            end else if (st_v[k]) begin
                md = m_run[j] ? m_mq[j] : md_v[k];
                if (!m_run[j]) m_mq[j] = md_v[k];
                sum = m_cnt[j] + stp;
                if (sum < int'(lim_v)) begin
                    m_cnt[j] = sum; m_run[j] = 1; m_done[j] = 0;
                end else begin
                    m_done[j] = 1;
                    m_run[j]  = 0;
                    m_sat[j]  = md;
                    m_cnt[j]  = md ? int'(lim_v) : 0;
                end
            end else begin
                m_done[j] = 0;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compare every output of both banks with the model.
    task automatic check_all(input string tag);
        logic [4*W-1:0] ea_cnt;
        logic [2*W-1:0] eb_cnt;
        logic [3:0]     ea_busy, ea_done;
        logic [1:0]     eb_busy, eb_done;
        logic           ea_idle, eb_idle;
        ea_idle = 1'b1;
        eb_idle = 1'b1;
        for (int j = 0; j < 4; j++) begin
            ea_cnt[j*W +: W] = W'(m_cnt[j]);
            ea_busy[j]       = m_run[j];
            ea_done[j]       = m_done[j];
            if (m_run[j] || m_sat[j]) ea_idle = 1'b0;
        end
        for (int j = 0; j < 2; j++) begin
            eb_cnt[j*W +: W] = W'(m_cnt[j+4]);
            eb_busy[j]       = m_run[j+4];
            eb_done[j]       = m_done[j+4];
            if (m_run[j+4] || m_sat[j+4]) eb_idle = 1'b0;
        end
        chk({tag, ".a_count"}, 32'(ifa.count), 32'(ea_cnt));
        chk({tag, ".a_busy"},  32'(ifa.busy),  32'(ea_busy));
        chk({tag, ".a_done"},  32'(ifa.done),  32'(ea_done));
        chk({tag, ".a_idle"},  32'(ifa.all_idle), 32'(ea_idle));
        chk({tag, ".b_count"}, 32'(ifb.count), 32'(eb_cnt));
        chk({tag, ".b_busy"},  32'(ifb.busy),  32'(eb_busy));
        chk({tag, ".b_done"},  32'(ifb.done),  32'(eb_done));
        chk({tag, ".b_idle"},  32'(ifb.all_idle), 32'(eb_idle));
    endtask

    // Apply one cycle of stimulus, step the model at the edge, and check 1 time unit later.
    task automatic cyc(input string tag, input logic [3:0] st, input logic [3:0] cl,
                       input logic [3:0] md, input logic [W-1:0] lim, input logic rs);
        st_v = st; cl_v = cl; md_v = md; lim_v = lim; rs_v = rs;
        reset     = rs;
        ifa.start = st;      ifa.clear = cl;      ifa.mode = md;      ifa.limit = lim;
        ifb.start = st[1:0]; ifb.clear = cl[1:0]; ifb.mode = md[1:0]; ifb.limit = lim;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
        $display("cyc %-8s st=%b cl=%b md=%b lim=%0d rst=%b | a_cnt=%h a_done=%b b_cnt=%h b_done=%b",
                 tag, st, cl, md, lim, rs, ifa.count, ifa.done, ifb.count, ifb.done);
    endtask

    initial begin : stim
        logic [7:0] wrap_exp [6];
        logic       wdone_exp [6];
        wrap_exp  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd1};
        wdone_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int j = 0; j < 6; j++) begin
            m_cnt[j] = 0; m_run[j] = 0; m_sat[j] = 0; m_mq[j] = 0; m_done[j] = 0;
        end
        #2;

        // Reset state.
        cyc("reset", 4'h0, 4'h0, 4'h0, 8'd5, 1'b1);
        cyc("reset", 4'hF, 4'h0, 4'h0, 8'd5, 1'b1);
        chk("reset_idle", 32'(ifa.all_idle), 32'd1);

        // Basic wrap: limit 5, start[0] held high.
        for (int i = 0; i < 6; i++) begin
            cyc("wrap", 4'b0001, 4'h0, 4'h0, 8'd5, 1'b0);
            chk("wrap_seq",  32'(ifa.count[7:0]), 32'(wrap_exp[i]));
            chk("wrap_done", 32'(ifa.done[0]),    32'(wdone_exp[i]));
        end

        // Pause and resume.
        cyc("clr", 4'h0, 4'hF, 4'h0, 8'd10, 1'b0);
        repeat (3) cyc("run",   4'b0001, 4'h0, 4'h0, 8'd10, 1'b0);
        repeat (4) cyc("pause", 4'b0000, 4'h0, 4'h0, 8'd10, 1'b0);
        chk("pause_busy", 32'(ifa.busy[0]), 32'd1);
        chk("pause_cnt",  32'(ifa.count[7:0]), 32'd3);
        repeat (2) cyc("resume", 4'b0001, 4'h0, 4'h0, 8'd10, 1'b0);
        chk("resume_cnt", 32'(ifa.count[7:0]), 32'd5);

        // Saturate with clear. Bank B channel 1 has STEP=3 and limit 4.
        cyc("clr", 4'h0, 4'hF, 4'h0, 8'd4, 1'b0);
        cyc("sat", 4'b0010, 4'h0, 4'b0010, 8'd4, 1'b0);
        chk("sat_b3", 32'(ifb.count[15:8]), 32'd3);
        cyc("sat", 4'b0010, 4'h0, 4'b0010, 8'd4, 1'b0);
        chk("sat_b4",    32'(ifb.count[15:8]), 32'd4);
        chk("sat_bdone", 32'(ifb.done[1]), 32'd1);
        repeat (3) cyc("sathold", 4'b0010, 4'h0, 4'b0000, 8'd9, 1'b0);
        chk("sat_hold", 32'(ifb.count[15:8]), 32'd4);
        cyc("satclr", 4'b0010, 4'b0010, 4'h0, 8'd9, 1'b0);
        chk("satclr_idle", 32'(ifb.all_idle), 32'd1);

        // Clear and terminal in the same cycle.
        cyc("clr", 4'h0, 4'hF, 4'h0, 8'd5, 1'b0);
        repeat (4) cyc("pre", 4'b0001, 4'h0, 4'h0, 8'd5, 1'b0);
        cyc("collide", 4'b0001, 4'b0001, 4'h0, 8'd5, 1'b0);
        chk("collide_done", 32'(ifa.done[0]), 32'd0);

        // Limit 0: wrap on channel 0, saturate on channel 2.
        cyc("lim0", 4'b0101, 4'h0, 4'b0100, 8'd0, 1'b0);
        chk("lim0_done", 32'(ifa.done), 32'b0101);
        cyc("lim0", 4'b0000, 4'h0, 4'b0000, 8'd0, 1'b0);
        cyc("clr",  4'h0, 4'hF, 4'h0, 8'd20, 1'b0);

        // Run to 8 with limit 20, then lower the limit to 6.
        repeat (8) cyc("to8", 4'b1001, 4'h0, 4'b1000, 8'd20, 1'b0);
        cyc("lower", 4'b1001, 4'h0, 4'b0000, 8'd6, 1'b0);
        chk("lower_sat", 32'(ifa.count[31:24]), 32'd6);
        chk("lower_wrap", 32'(ifa.count[7:0]), 32'd0);
        cyc("clr", 4'h0, 4'hF, 4'h0, 8'd10, 1'b0);

        // The mode latched at start determines the terminal behaviour.
        repeat (2) cyc("mlatch", 4'b0001, 4'h0, 4'b0001, 8'd10, 1'b0);
        repeat (8) cyc("mlatch", 4'b0001, 4'h0, 4'b0000, 8'd10, 1'b0);
        chk("mlatch_sat", 32'(ifa.count[7:0]), 32'd10);
        cyc("clr", 4'h0, 4'hF, 4'h0, 8'd8, 1'b0);

        // Reset at count 7 while a terminal step is due.
        repeat (7) cyc("pre_rst", 4'b0001, 4'h0, 4'h0, 8'd8, 1'b0);
        cyc("midrst", 4'b0001, 4'h0, 4'h0, 8'd8, 1'b1);
        chk("midrst_done", 32'(ifa.done), 32'd0);

        // Randomized operation.
        for (int i = 0; i < 400; i++) begin
            logic [3:0] st, cl, md;
            logic       rs;
            st = 4'($urandom) | 4'($urandom);
            cl = 4'($urandom) & 4'($urandom) & 4'($urandom);
            md = 4'($urandom);
            rs = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 7) == 0)
                lim_v = ($urandom_range(0, 9) == 0) ? W'($urandom) : W'($urandom_range(0, 25));
            cyc("rand", st, cl, md, lim_v, rs);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
